vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

VGA 640x480@60 Hz raster timing generator: the source end of the `hCount`/`vCount`/`bright` interface that the pixel-colour controllers consume. It divides the 100 MHz board clock down to a pixel-rate strobe, runs the horizontal and vertical counters, and drives the sync, blanking and frame/line marker outputs. All outputs are registered and mutually aligned, so consumers see consistent coordinates and blanking in the same cycle.

## Interface
- `DIV`, 4: clk cycles per pixel; legal range 1..16. At 100 MHz, 4 gives 25 MHz.
- `H_SYNC`, 96: hsync pulse width, pixels.
- `H_BP`, 48: horizontal back porch, pixels.
- `H_ACT`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, pixels.
- `V_SYNC`, 2: vsync pulse width, lines.
- `V_BP`, 33: vertical back porch, lines.
- `V_ACT`, 480: visible lines.
- `V_FP`, 10: vertical front porch, lines.
- `SYNC_POL`, 0: active level of hSync/vSync; 0 means active-low.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; asynchronous, active-high.
- `pix_en`  out  1  one-clk strobe, high in the cycle after each counter update.
- `hCount`  out  10  horizontal position, 0..H_TOT-1. H_TOT = H_SYNC+H_BP+H_ACT+H_FP = 800.
- `vCount`  out  10  vertical position, 0..V_TOT-1. V_TOT = 525.
- `hSync`  out  1  horizontal sync.
- `vSync`  out  1  vertical sync.
- `bright`  out  1  high when the current (hCount, vCount) is visible.
- `line_start`  out  1  one-clk pulse, coincident with `pix_en`, when hCount has just wrapped to 0.
- `frame_start`  out  1  one-clk pulse, coincident with `pix_en`, when (hCount, vCount) has just become (0, 0).
- `frame_cnt`  out  8  completed-frame counter; wraps 255→0.

## Operation
- **Pixel divider.** Internal `div_cnt`, 0..DIV-1, increments every clk and wraps to 0. `tick` = (div_cnt == DIV-1).
- **Counter advance (on a tick edge).**
  - hCount increments.
  - At H_TOT-1, hCount wraps to 0 and vCount increments.
  - At (H_TOT-1, V_TOT-1), both wrap to 0 and frame_cnt increments.
- **Sync and blanking.** Computed from the *next* counter values and registered alongside them, so they always match the hCount/vCount on the outputs:
  - hSync is at its active level iff hCount < H_SYNC.
  - vSync is at its active level iff vCount < V_SYNC.
  - bright = (H_SYNC+H_BP ≤ hCount < H_SYNC+H_BP+H_ACT) && (V_SYNC+V_BP ≤ vCount < V_SYNC+V_BP+V_ACT).
  - With defaults, the visible area is hCount 144..783 and vCount 35..514.
- **Strobes.** `pix_en` is a registered copy of tick. `line_start` = pix_en && hCount==0. `frame_start` = pix_en && hCount==0 && vCount==0.
- **Reset values.** div_cnt=0, hCount=0, vCount=0, frame_cnt=0. hSync=vSync=SYNC_POL (active, consistent with count 0). bright=0. pix_en=0, line_start=0, frame_start=0.
- **Reset mid-frame.** Asynchronous return to the reset values; there is no partial-line recovery. Timing restarts at (0, 0), with no frame_start pulse for that restart.
- **DIV=1.** tick is constantly high and counters advance every clk. pix_en is 0 in the first cycle after reset, then constantly high.

## Timing
- After rst deasserts, the first counter advance (hCount 0→1) occurs on the DIV-th rising clk edge. pix_en is high in the following cycle.
- Line period: DIV×H_TOT clk cycles (3200 with defaults).
- Frame period: DIV×H_TOT×V_TOT clk cycles (1,680,000 with defaults).
- Latency is zero between the counters and sync/bright: all outputs change on the same clk edge.
- hSync active width: H_SYNC×DIV clks (384). vSync active width: V_SYNC×H_TOT×DIV clks (6400).
- frame_start fires once per frame, except after reset.
- frame_cnt changes on the same edge as the vCount wrap.

## Test plan
- **Reset and first steps.** Hold rst for 3 clks, release, run 8 clks with defaults.
  - Required: hCount 0→1 on edge 4 and 1→2 on edge 8; pix_en high in cycles 5 and 9 only; hSync=vSync=0 and bright=0 throughout.
- **Line boundaries.** Run to hCount=799, then one more pixel.
  - Required: hCount=0, vCount incremented, line_start pulses for exactly 1 clk.
  - Also required: hSync low for hCount 0..95 and high at 96.
  - Also required: bright rises exactly at hCount=144 and falls at hCount=784 on line vCount=35.
- **Frame wrap.** Run a full frame (1,680,000 clks).
  - Required: at (799, 524)→(0, 0), frame_start pulses once and frame_cnt goes 0→1.
  - Also required: vSync low for vCount 0..1 only; bright=0 for vCount 515..524 and 0..34.
- **Counter extremes.** Force 256 frames with a reduced-timing parameter set (H_TOT=16, V_TOT=8).
  - Required: frame_cnt wraps 255→0.
  - Also required: no hCount/vCount values outside their legal ranges are ever seen.
- **Parameter variants.** DIV=1 with SYNC_POL=1.
  - Required: counters advance every clk; pix_en constantly high after the first cycle; sync outputs active-high with widths 96 clks and 1600 clks.
- **Mid-frame reset.** Assert rst asynchronously, between clock edges, at vCount=200, hCount=500.
  - Required: all outputs take their reset values immediately.
  - Also required: restart timing identical to the first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 Hz raster timing source. Divides clk down to a pixel-rate tick,
// runs the horizontal/vertical position counters and a completed-frame counter,
// and drives sync, blanking and line/frame marker outputs. Every output is a
// register loaded on the same clk edge, so coordinates, syncs and blanking
// always describe the same pixel.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   asynchronous, active-high reset
//   pix_en       out  one-clk strobe in the cycle after each counter update
//   hCount[9:0]  out  horizontal position, 0..H_TOT-1
//   vCount[9:0]  out  vertical position, 0..V_TOT-1
//   hSync        out  horizontal sync, active level SYNC_POL
//   vSync        out  vertical sync, active level SYNC_POL
//   bright       out  current (hCount, vCount) lies in the visible area
//   line_start   out  pulse with pix_en when hCount has just wrapped to 0
//   frame_start  out  pulse with pix_en when position has just become (0, 0)
//   frame_cnt    out  completed-frame counter, wraps 255 -> 0
module vga_timing_gen #(
  parameter int DIV      = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  // DIV=1 still needs a one-bit divider register; it simply never leaves 0.
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_BEG  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS_END  = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_VIS_BEG  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS_END  = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic       SYNC_ON    = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] div_next_s;
  logic          tick_s;
  logic [9:0]    h_next_s;
  logic [9:0]    v_next_s;
  logic [7:0]    frame_next_s;
  logic          hsync_next_s;
  logic          vsync_next_s;
  logic          bright_next_s;
  logic          line_next_s;
  logic          frame_start_next_s;

  // Next-state for divider and position/frame counters.
  always_comb begin
    tick_s       = (div_cnt_r == DIV_LAST);
    div_next_s   = div_cnt_r;
    h_next_s     = hCount;
    v_next_s     = vCount;
    frame_next_s = frame_cnt;
    if (tick_s) begin
      div_next_s = {DW{1'b0}};
      if (hCount == H_LAST) begin
        h_next_s = 10'd0;
        if (vCount == V_LAST) begin
          v_next_s     = 10'd0;
          frame_next_s = frame_cnt + 8'd1;
        end else begin
          v_next_s = vCount + 10'd1;
        end
      end else begin
        h_next_s = hCount + 10'd1;
      end
    end else begin
      div_next_s = div_cnt_r + DW'(1);
    end
  end

  // Sync/blank/marker values decoded from the next position so they are
  // registered on the same edge as the counters they describe.
  always_comb begin
    hsync_next_s       = (h_next_s < H_SYNC_END) ? SYNC_ON : ~SYNC_ON;
    vsync_next_s       = (v_next_s < V_SYNC_END) ? SYNC_ON : ~SYNC_ON;
    bright_next_s      = (h_next_s >= H_VIS_BEG) && (h_next_s < H_VIS_END) &&
                         (v_next_s >= V_VIS_BEG) && (v_next_s < V_VIS_END);
    // Markers need tick so that the reset restart at (0, 0) produces no pulse.
    line_next_s        = tick_s && (h_next_s == 10'd0);
    frame_start_next_s = tick_s && (h_next_s == 10'd0) && (v_next_s == 10'd0);
  end

  // Output and state registers; reset puts syncs at their active level to
  // match the (0, 0) position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r   <= {DW{1'b0}};
      hCount      <= 10'd0;
      vCount      <= 10'd0;
      frame_cnt   <= 8'd0;
      hSync       <= SYNC_ON;
      vSync       <= SYNC_ON;
      bright      <= 1'b0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt_r   <= div_next_s;
      hCount      <= h_next_s;
      vCount      <= v_next_s;
      frame_cnt   <= frame_next_s;
      hSync       <= hsync_next_s;
      vSync       <= vsync_next_s;
      bright      <= bright_next_s;
      pix_en      <= tick_s;
      line_start  <= line_next_s;
      frame_start <= frame_start_next_s;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing (DIV=4), a DIV=1 active-high
// sync variant, and a reduced 16x8 raster used for frame wrap and frame_cnt rollover.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;

  logic       pe [3];
  logic       hs [3];
  logic       vs [3];
  logic       br [3];
  logic       ls [3];
  logic       fs [3];
  logic [9:0] hc [3];
  logic [9:0] vc [3];
  logic [7:0] fc [3];

  int errors = 0;
  int checks = 0;

  int hs_cnt = 0;
  int vs_cnt = 0;
  int pe_cnt = 0;
  int bad_range = 0;
  int bad_model = 0;
  int bad_sync = 0;
  int n_fs = 0;
  int n_ls = 0;
  int eh, ev, ef;
  logic ehs, evs, ebr;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst0), .pix_en(pe[0]), .hCount(hc[0]), .vCount(vc[0]),
    .hSync(hs[0]), .vSync(vs[0]), .bright(br[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .frame_cnt(fc[0])
  );

  vga_timing_gen #(.DIV(1), .SYNC_POL(1)) u_fast (
    .clk(clk), .rst(rst1), .pix_en(pe[1]), .hCount(hc[1]), .vCount(vc[1]),
    .hSync(hs[1]), .vSync(vs[1]), .bright(br[1]), .line_start(ls[1]),
    .frame_start(fs[1]), .frame_cnt(fc[1])
  );

  vga_timing_gen #(
    .DIV(1), .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(3),
    .V_SYNC(1), .V_BP(2), .V_ACT(3), .V_FP(2), .SYNC_POL(0)
  ) u_small (
    .clk(clk), .rst(rst2), .pix_en(pe[2]), .hCount(hc[2]), .vCount(vc[2]),
    .hSync(hs[2]), .vSync(vs[2]), .bright(br[2]), .line_start(ls[2]),
    .frame_start(fs[2]), .frame_cnt(fc[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until instance s shows (h, v) in a fresh pixel cycle, bounded by budget.
  task automatic wait_pos(input int s, input logic [9:0] h, input logic [9:0] v,
                          input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (pe[s] === 1'b1 && hc[s] === h && vc[s] === v) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hc"}, hc[0], 32'd0);
    chk({tag, "_vc"}, vc[0], 32'd0);
    chk({tag, "_fc"}, fc[0], 32'd0);
    chk({tag, "_flags"}, {pe[0], ls[0], fs[0], hs[0], vs[0], br[0]}, 32'd0);
  endtask

  // Hold reset 3 clks, release, then 8 clks: hCount steps on edges 4 and 8.
  task automatic first_steps(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check_reset({tag, "_rst"});
    rst0 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      chk({tag, "_h"}, hc[0], (e >= 8) ? 32'd2 : ((e >= 4) ? 32'd1 : 32'd0));
      chk({tag, "_pix"}, pe[0], (e == 4 || e == 8) ? 32'd1 : 32'd0);
      chk({tag, "_syncbr"}, {hs[0], vs[0], br[0]}, 32'd0);
    end
  endtask

  initial begin
    // Reset and first steps, default timing.
    first_steps("first");

    // hSync boundary and line wrap.
    wait_pos(0, 10'd95, 10'd0, 4000, "wait_h95");
    chk("hsync_at95", hs[0], 32'd0);
    step(4);
    chk("h_96", hc[0], 32'd96);
    chk("hsync_at96", hs[0], 32'd1);
    wait_pos(0, 10'd799, 10'd0, 4000, "wait_h799");
    chk("ls_at799", ls[0], 32'd0);
    step(3);
    chk("hold_799", hc[0], 32'd799);
    chk("pix_off", pe[0], 32'd0);
    step(1);
    chk("wrap_h", hc[0], 32'd0);
    chk("wrap_v", vc[0], 32'd1);
    chk("wrap_ls", ls[0], 32'd1);
    chk("wrap_fs", fs[0], 32'd0);
    chk("wrap_hsync", hs[0], 32'd0);
    step(1);
    chk("ls_one_clk", ls[0], 32'd0);

    // Mid-frame asynchronous reset, between clock edges.
    wait_pos(0, 10'd500, 10'd1, 4000, "wait_mid");
    chk("mid_hsync_inactive", hs[0], 32'd1);
    #2;
    rst0 = 1'b1;
    #1;
    check_reset("midrst");
    first_steps("restart");

    // DIV=1, active-high syncs.
    rst1 = 1'b0;
    chk("fast_pix_first", pe[1], 32'd0);
    for (int k = 0; k < 2400; k++) begin
      if (k > 0) step(1);
      hs_cnt += int'(hs[1]);
      vs_cnt += int'(vs[1]);
      pe_cnt += int'(pe[1]);
    end
    chk("fast_h_end", hc[1], 32'd799);
    chk("fast_v_end", vc[1], 32'd2);
    chk("fast_hsync_w", hs_cnt, 32'd288);
    chk("fast_vsync_w", vs_cnt, 32'd1600);
    chk("fast_pix_cnt", pe_cnt, 32'd2399);

    // Visible-area edges on line 35.
    wait_pos(1, 10'd143, 10'd35, 30000, "wait_143");
    chk("br_143", br[1], 32'd0);
    step(1);
    chk("h_144", hc[1], 32'd144);
    chk("br_144", br[1], 32'd1);
    wait_pos(1, 10'd783, 10'd35, 1000, "wait_783");
    chk("br_783", br[1], 32'd1);
    step(1);
    chk("h_784", hc[1], 32'd784);
    chk("br_784", br[1], 32'd0);

    // Reduced 16x8 raster: 256 frames, frame_cnt rollover.
    rst2 = 1'b0;
    for (int k = 1; k <= 32768; k++) begin
      step(1);
      eh  = k % 16;
      ev  = (k / 16) % 8;
      ef  = (k / 128) % 256;
      ehs = (eh < 2) ? 1'b0 : 1'b1;
      evs = (ev < 1) ? 1'b0 : 1'b1;
      ebr = (eh >= 5 && eh < 13 && ev >= 3 && ev < 6) ? 1'b1 : 1'b0;
      if (int'(hc[2]) > 15 || int'(vc[2]) > 7) bad_range++;
      if (int'(hc[2]) != eh || int'(vc[2]) != ev || int'(fc[2]) != ef) bad_model++;
      if (hs[2] !== ehs || vs[2] !== evs || br[2] !== ebr) bad_sync++;
      n_fs += int'(fs[2]);
      n_ls += int'(ls[2]);
      if (k == 127) begin
        chk("sm_last_h", hc[2], 32'd15);
        chk("sm_last_v", vc[2], 32'd7);
        chk("sm_last_fs", fs[2], 32'd0);
        chk("sm_last_fc", fc[2], 32'd0);
      end
      if (k == 128) begin
        chk("sm_wrap_hv", {hc[2], vc[2]}, 32'd0);
        chk("sm_wrap_fs", fs[2], 32'd1);
        chk("sm_wrap_ls", ls[2], 32'd1);
        chk("sm_wrap_fc", fc[2], 32'd1);
      end
      if (k == 129) chk("sm_fs_one_clk", fs[2], 32'd0);
      if (k == 32767) chk("sm_fc_255", fc[2], 32'd255);
      if (k == 32768) begin
        chk("sm_fc_rollover", fc[2], 32'd0);
        chk("sm_fs_rollover", fs[2], 32'd1);
      end
    end
    chk("sm_range", bad_range, 32'd0);
    chk("sm_model", bad_model, 32'd0);
    chk("sm_sync_bright", bad_sync, 32'd0);
    chk("sm_fs_count", n_fs, 32'd256);
    chk("sm_ls_count", n_ls, 32'd2048);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
